// File: rtl/fp_div_iter_pkg.sv
// Shared types and constants for the iterative floating-point divider and
// its neighbours in the FALU.
package fp_div_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] FALU_ADD = 4'd0;
    localparam logic [3:0] FALU_SUB = 4'd1;
    localparam logic [3:0] FALU_MUL = 4'd2;
    localparam logic [3:0] FALU_DIV = 4'd3;

    localparam logic [31:0]        FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]         FP_EXP_MAX = 8'hFF;
    localparam logic signed [9:0]  FP_BIAS    = 10'sd127;
    localparam logic signed [9:0]  FP_EXP_OVF = 10'sd255;
    localparam logic [4:0]         DIV_LAST   = 5'd24;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, FP_EXP_MAX, 23'd0};
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: trial subtract, produce one quotient bit and
// the left-shifted partial remainder for the next step.
module fp_div_step (
    input  logic [25:0] rem,
    input  logic [23:0] divisor,
    output logic [25:0] rem_next,
    output logic        q_bit
);

    logic [25:0] diff;

    always_comb begin
        diff     = rem - {2'b00, divisor};
        q_bit    = (rem >= {2'b00, divisor});
        rem_next = q_bit ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: restoring division, one
// quotient bit per cycle, round to nearest even, operands with exponent 0 are zero.
//
// state  | meaning
// IDLE   | waiting for an operand pair
// DIVIDE | 25 restoring steps: 24 significand bits plus guard
// ROUND  | round, range-check exponent, register result
// DONE   | result presented until the consumer accepts it
module fp_div_iter
    import fp_div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [24:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [31:0]        result_q, result_d;

    logic [25:0]        step_rem;
    logic               step_q;

    logic [7:0]         e1, e2;
    logic [23:0]        m1, m2;
    logic               sign_in, op1_zero, op2_zero, is_nan;
    logic signed [9:0]  e_raw;

    logic               sticky, inc;
    logic [24:0]        sig_inc;
    logic [22:0]        frac_rnd;
    logic signed [9:0]  exp_rnd;
    logic [31:0]        rounded;

    fp_div_step u_step (
        .rem      (rem_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        e1       = op1[30:23];
        e2       = op2[30:23];
        m1       = {1'b1, op1[22:0]};
        m2       = {1'b1, op2[22:0]};
        sign_in  = op1[31] ^ op2[31];
        op1_zero = (e1 == 8'd0);
        op2_zero = (e2 == 8'd0);
        is_nan   = (e1 == FP_EXP_MAX) || (e2 == FP_EXP_MAX) || (op1_zero && op2_zero);
        e_raw    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + FP_BIAS;
    end

    // Quotient register holds {leading 1, 23 fraction bits, guard}.
    always_comb begin
        sticky  = (rem_q != 26'd0);
        inc     = quo_q[0] & (sticky | quo_q[1]);
        sig_inc = {1'b0, quo_q[24:1]} + {24'd0, inc};
        if (sig_inc[24]) begin
            frac_rnd = sig_inc[23:1];
            exp_rnd  = exp_q + 10'sd1;
        end else begin
            frac_rnd = sig_inc[22:0];
            exp_rnd  = exp_q;
        end
        if (exp_rnd >= FP_EXP_OVF) begin
            rounded = fp_inf(sign_q);
        end else if (exp_rnd <= 10'sd0) begin
            rounded = fp_zero(sign_q);
        end else begin
            rounded = {sign_q, exp_rnd[7:0], frac_rnd};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = sign_in;
                    state_d = ST_DONE;
                    if (is_nan) begin
                        result_d = FP_QNAN;
                    end else if (op2_zero) begin
                        result_d = fp_inf(sign_in);
                    end else if (op1_zero) begin
                        result_d = fp_zero(sign_in);
                    end else begin
                        // Pre-align so the first quotient bit is always 1.
                        if (m1 < m2) begin
                            rem_d = {1'b0, m1, 1'b0};
                            exp_d = e_raw - 10'sd1;
                        end else begin
                            rem_d = {2'b00, m1};
                            exp_d = e_raw;
                        end
                        div_d   = m2;
                        quo_d   = 25'd0;
                        cnt_d   = DIV_LAST;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                rem_d = step_rem;
                quo_d = {quo_q[23:0], step_q};
                if (cnt_q == 5'd0) begin
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_ROUND: begin
                result_d = rounded;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 26'd0;
            div_q    <= 24'd0;
            quo_q    <= 25'd0;
            exp_q    <= 10'sd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    // in_ready is masked by rst so a request can never win against reset.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: directed vectors push expected results,
// a negedge monitor checks latency, hold stability and the accepted result.
module tb_fp_div_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          lat_cnt = 0;
    bit          got_valid = 0;
    logic [31:0] held;

    fp_div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: latency counts negedges from the handshake edge to first valid.
    always @(negedge clk) begin
        if (rst) begin
            got_valid = 0;
            lat_cnt   = 0;
        end else if (exp_q.size() == 0) begin
            if (out_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL stale_out: out_valid=1 result=%h with nothing expected", result);
            end
        end else begin
            if (!got_valid) begin
                lat_cnt++;
                if (out_valid) begin
                    got_valid = 1;
                    held      = result;
                    n_vec++;
                    if (lat_cnt != exp_q[0].lat) begin
                        n_err++;
                        $display("FAIL latency: got %0d expected %0d", lat_cnt, exp_q[0].lat);
                    end
                end else if (lat_cnt > 40) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL timeout: no out_valid after %0d cycles, expected %h", lat_cnt, exp_q[0].res);
                    void'(exp_q.pop_front());
                    lat_cnt = 0;
                end
            end else begin
                n_vec++;
                if (!out_valid || result !== held) begin
                    n_err++;
                    $display("FAIL hold: out_valid=%b result=%h expected 1 %h", out_valid, result, held);
                end
            end
            if (got_valid && out_valid && out_ready) begin
                chk("result", result, exp_q[0].res);
                void'(exp_q.pop_front());
                got_valid = 0;
                lat_cnt   = 0;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat);
        int t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        op1      = a;
        op2      = b;
        @(posedge clk);
        e.res = r;
        e.lat = lat;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 11;
    logic [31:0] tv_a [NV] = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000,
                               32'h0000_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000,
                               32'h8000_0000, 32'h7F80_0000, 32'h3FC0_0000};
    logic [31:0] tv_b [NV] = '{32'h4000_0000, 32'h4040_0000, 32'hC080_0000, 32'h0000_0000,
                               32'h0000_0000, 32'h3E80_0000, 32'h7E80_0000, 32'h3F80_0000,
                               32'h4000_0000, 32'h3F80_0000, 32'hBF00_0000};
    logic [31:0] tv_r [NV] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hBE80_0000, 32'h7F80_0000,
                               32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000,
                               32'h8000_0000, 32'h7FC0_0000, 32'hC040_0000};
    int          tv_l [NV] = '{27, 27, 27, 1, 1, 27, 27, 27, 1, 1, 27};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op1       = 32'd0;
        op2       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            send(tv_a[i], tv_b[i], tv_r[i], tv_l[i]);
            drain();
        end

        // Consumer stalls for 10 cycles in DONE.
        out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("s4_valid", {31'd0, out_valid}, 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("s4_in_ready_hold", {31'd0, in_ready}, 32'd0);
            chk("s4_busy_hold", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("s4_in_ready_before", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("s4_in_ready_rise", {31'd0, in_ready}, 32'd1);
        drain();

        // Reset 10 cycles into DIVIDE discards the operation.
        send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);
        repeat (10) @(posedge clk);
        #1;
        chk("s6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("s6_rst_busy", {31'd0, busy}, 32'd0);
        chk("s6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("s6_still_idle", {31'd0, busy}, 32'd0);
        send(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 27);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_div_iter.md
FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: request carries a valid operand pair.
REQ-004 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-005 SHALL have ports op1 and op2, input, 32 bits each: IEEE-754 single-precision dividend and divisor.
REQ-006 SHALL have port out_valid, output, 1 bit: result is valid; high only in DONE.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-008 SHALL have port result, output, 32 bits: quotient op1/op2.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, DIVIDE, ROUND, DONE.
REQ-011 Request handshake SHALL be in_valid & in_ready. On the handshake edge, op1 and op2 are captured and inputs are ignored until the next IDLE.
REQ-012 Special cases (op1 or op2 exponent 255, or 0/0) SHALL give NaN 0x7FC00000 and go IDLE->DONE.
REQ-013 Divisor exponent 0 with op1 nonzero SHALL give {sign, 0xFF, 0}.
REQ-014 Dividend exponent 0 with op2 nonzero SHALL give {sign, 0, 0}.
REQ-015 Any exponent-0 operand SHALL be treated as zero; no denormal support.
REQ-016 Sign SHALL be op1[31] ^ op2[31], including for the special cases in REQ-013 and REQ-014.
REQ-017 Normal operands: mantissas m1 and m2 SHALL be {1, frac}, 24 bits. Exponent SHALL be 10-bit signed e = e1 - e2 + 127. If m1 < m2, m1 SHALL be shifted left 1 and e decremented, so the quotient lies in [1,2).
REQ-018 DIVIDE SHALL run restoring division, one quotient bit per cycle, for exactly 25 cycles: 24 significand bits plus the guard bit. Sticky SHALL be (final remainder != 0).
REQ-019 ROUND SHALL round to nearest, ties to even: increment if guard & (sticky | lsb). If the increment carries out, SHALL renormalise and increment e. The state then becomes DONE.
REQ-020 After rounding, e >= 255 SHALL give ±infinity and e <= 0 SHALL give ±0 (flush).
REQ-021 Latency SHALL be:
- normal operands: out_valid first high 27 cycles after the handshake edge;
- special cases: out_valid high 1 cycle after the handshake edge.
REQ-022 DONE SHALL hold result and out_valid stable until out_valid & out_ready.
REQ-023 On that edge the state SHALL return to IDLE. in_ready SHALL rise the cycle after, so there is no back-to-back accept.
REQ-024 result SHALL be registered; no combinational path from the inputs to result or out_valid.

Reset
REQ-025 While rst is high, the FSM SHALL be in IDLE, and out_valid=0, busy=0, result=0, in_ready=0.
REQ-026 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-027 rst during DIVIDE, ROUND or DONE SHALL abort the operation with no output; the discarded result is never presented.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 The state enum, the NaN/infinity constants and the bias 127 SHALL live in the shared package alongside the `FALU_* op codes.
REQ-030 The restoring-division step (remainder, divisor -> next remainder, quotient bit) SHALL be the combinational sub-module fp_div_step.
REQ-031 Target size is 150-300 lines of RTL.

Verification
REQ-032 Scenario 1: 0x40C00000 / 0x40000000 (6.0/2.0) SHALL give result 0x40400000 with out_valid 27 cycles after accept.
REQ-033 Scenario 2: 0x3F800000 / 0x40400000 (1.0/3.0) SHALL give 0x3EAAAAAB (rounding up).
REQ-034 Scenario 3: 0x3F800000 / 0xC0800000 SHALL give 0xBE800000. Then 0x40000000 / 0x00000000 SHALL give 0x7F800000 one cycle after accept, and 0/0 SHALL give 0x7FC00000.
REQ-035 Scenario 4: holding out_ready=0 for 10 cycles in DONE SHALL keep result and out_valid stable. in_ready SHALL stay 0 throughout and rise exactly one cycle after out_ready is asserted.
REQ-036 Scenario 5: 0x7F000000 / 0x3E800000 SHALL give 0x7F800000 (overflow). 0x00800000 / 0x7E800000 SHALL give 0x00000000 (underflow).
REQ-037 Scenario 6: rst pulsed 10 cycles into DIVIDE SHALL give IDLE, out_valid=0 and in_ready=1 after rst deasserts, and no stale result ever appears. A following request SHALL complete correctly.
